// File: rtl/fp_accum_ctrl.sv
// Packet accumulator sequencer driving the shared single-precision FP adder.
// Define FP_ACC_ZERO_SKIP_EN to absorb non-first +/-0 terms without an adder transaction.
module fp_accum_ctrl #(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [31:0]      in_data,
  input  logic             in_last,
  output logic             in_ready,
  output logic             add_load,
  output logic [31:0]      add_a,
  output logic [31:0]      add_b,
  input  logic [31:0]      add_result,
  input  logic             add_result_ready,
  output logic             add_result_ack,
  output logic             sum_valid,
  output logic [31:0]      sum_data,
  input  logic             sum_ack,
  output logic [CNT_W-1:0] term_count,
  output logic             err_timeout
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {IDLE, LOAD, WAIT, ACK, DONE} state_t;

  state_t        state;
  logic [31:0]   acc;
  logic          acc_empty;
  logic          last_q;
  logic [TW-1:0] tcnt;
  logic          zero_skip;

`ifdef FP_ACC_ZERO_SKIP_EN
  assign zero_skip = (in_data[30:0] == 31'd0);
`else
  assign zero_skip = 1'b0;
`endif

  // The accumulator only changes outside DONE, so it doubles as the held sum.
  assign sum_data = acc;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == {CNT_W{1'b1}}) ? c : c + CNT_W'(1);
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      acc            <= '0;
      acc_empty      <= 1'b1;
      last_q         <= 1'b0;
      tcnt           <= '0;
      in_ready       <= 1'b0;
      add_load       <= 1'b0;
      add_a          <= '0;
      add_b          <= '0;
      add_result_ack <= 1'b0;
      sum_valid      <= 1'b0;
      term_count     <= '0;
      err_timeout    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            if (acc_empty || zero_skip) begin
              // First term seeds the accumulator; skipped zeros leave it alone.
              if (acc_empty) begin
                acc        <= in_data;
                acc_empty  <= 1'b0;
                term_count <= CNT_W'(1);
              end else begin
                term_count <= sat_inc(term_count);
              end
              if (in_last) begin
                state     <= DONE;
                sum_valid <= 1'b1;
                in_ready  <= 1'b0;
              end
            end else begin
              add_a      <= acc;
              add_b      <= in_data;
              add_load   <= 1'b1;
              last_q     <= in_last;
              term_count <= sat_inc(term_count);
              in_ready   <= 1'b0;
              state      <= LOAD;
            end
          end
        end
        LOAD: begin
          add_load <= 1'b0;
          tcnt     <= '0;
          state    <= WAIT;
        end
        WAIT: begin
          if (add_result_ready) begin
            acc            <= add_result;
            add_result_ack <= 1'b1;
            state          <= ACK;
          end else if (tcnt == TW'(TIMEOUT - 1)) begin
            // Ack anyway so a stuck adder is flushed; keep the pre-add sum.
            err_timeout    <= 1'b1;
            add_result_ack <= 1'b1;
            state          <= ACK;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
        ACK: begin
          add_result_ack <= 1'b0;
          if (last_q) begin
            state     <= DONE;
            sum_valid <= 1'b1;
          end else begin
            state    <= IDLE;
            in_ready <= 1'b1;
          end
        end
        DONE: begin
          if (sum_ack) begin
            sum_valid   <= 1'b0;
            acc_empty   <= 1'b1;
            term_count  <= '0;
            err_timeout <= 1'b0;
            in_ready    <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_accum_ctrl.sv
// Directed bench for fp_accum_ctrl with a table-driven stand-in for the FP adder
// (result_ready two edges after it samples load, dropped on ack).
module tb_fp_accum_ctrl;

  localparam int CNT_W   = 16;
  localparam int TIMEOUT = 15;

  logic             clk;
  logic             reset;
  logic             in_valid;
  logic [31:0]      in_data;
  logic             in_last;
  logic             in_ready;
  logic             add_load;
  logic [31:0]      add_a;
  logic [31:0]      add_b;
  logic [31:0]      add_result;
  logic             add_result_ready;
  logic             add_result_ack;
  logic             sum_valid;
  logic [31:0]      sum_data;
  logic             sum_ack;
  logic [CNT_W-1:0] term_count;
  logic             err_timeout;

  fp_accum_ctrl #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
    .add_load(add_load), .add_a(add_a), .add_b(add_b),
    .add_result(add_result), .add_result_ready(add_result_ready),
    .add_result_ack(add_result_ack),
    .sum_valid(sum_valid), .sum_data(sum_data), .sum_ack(sum_ack),
    .term_count(term_count), .err_timeout(err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Adder stand-in: hand-computed sums for the operand pairs used below.
  function automatic logic [31:0] fp_tbl(input logic [31:0] a, input logic [31:0] b);
    case ({a, b})
      {32'h3F800000, 32'h40000000}: return 32'h40400000;
      {32'h3F800000, 32'h00000000}: return 32'h3F800000;
      {32'h3F800000, 32'h80000000}: return 32'h3F800000;
      {32'h40400000, 32'h3F800000}: return 32'h40800000;
      {32'h40000000, 32'h3F800000}: return 32'h40400000;
      default:                      return 32'h7FC00001;
    endcase
  endfunction

  logic        stub_dead;
  logic        pend;
  logic        dly;
  int          cyc = 0;
  int          loads = 0;
  int          acks = 0;
  int          load_cyc = 0;
  int          ack_cyc = 0;
  logic [31:0] cap_a, cap_b;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      add_result_ready <= 1'b0;
      add_result       <= '0;
      pend             <= 1'b0;
      dly              <= 1'b0;
    end else begin
      cyc <= cyc + 1;
      if (add_load) begin
        pend       <= 1'b1;
        dly        <= 1'b0;
        add_result <= fp_tbl(add_a, add_b);
        cap_a      <= add_a;
        cap_b      <= add_b;
        loads      <= loads + 1;
        load_cyc   <= cyc;
      end else if (pend && !stub_dead) begin
        if (dly) begin
          add_result_ready <= 1'b1;
          pend             <= 1'b0;
        end else begin
          dly <= 1'b1;
        end
      end
      if (add_result_ack) begin
        add_result_ready <= 1'b0;
        pend             <= 1'b0;
        acks             <= acks + 1;
        ack_cyc          <= cyc;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [31:0] d, input logic l);
    int n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      n_tests++;
      n_fail++;
      $display("FAIL send_wait: in_ready low after %0d cycles, required high", n);
    end else begin
      @(posedge clk);
    end
    #1 in_valid = 1'b0;
    in_last = 1'b0;
  endtask

  // Counts negedges with sum_valid low before it rises.
  task automatic wait_sum(input int max, output int n);
    n = 0;
    while (1) begin
      @(negedge clk);
      if (sum_valid) break;
      n++;
      if (n >= max) begin
        n_tests++;
        n_fail++;
        $display("FAIL sum_wait: sum_valid low after %0d cycles, required high", n);
        break;
      end
    end
  endtask

  task automatic take_sum(input string tag);
    @(negedge clk);
    sum_ack = 1'b1;
    @(posedge clk);
    #1 sum_ack = 1'b0;
    chk({tag, "_sv_clr"}, sum_valid, 0);
    chk({tag, "_cnt_clr"}, term_count, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int gap, l0, a0;
    logic stable;
    logic [31:0] sd;

    reset = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
    sum_ack = 1'b0; stub_dead = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_flags", {27'd0, in_ready, add_load, add_result_ack, sum_valid, err_timeout}, 0);
    chk("rst_sum", sum_data, 0);
    chk("rst_cnt", term_count, 0);
    reset = 1'b1;
    @(negedge clk);
    chk("rel_ready", in_ready, 1);

    // Single-term packet bypasses the adder.
    l0 = loads;
    send(32'h3F800000, 1'b1);
    wait_sum(50, gap);
    chk("single_gap", gap, 0);
    chk("single_sum", sum_data, 32'h3F800000);
    chk("single_cnt", term_count, 1);
    chk("single_loads", loads - l0, 0);
    take_sum("single");

    // 1.0 + 2.0 through the adder.
    l0 = loads; a0 = acks;
    send(32'h3F800000, 1'b0);
    chk("two_cnt1", term_count, 1);
    chk("two_ready1", in_ready, 1);
    send(32'h40000000, 1'b1);
    wait_sum(50, gap);
    chk("two_gap", gap, 5);
    chk("two_sum", sum_data, 32'h40400000);
    chk("two_cnt", term_count, 2);
    chk("two_loads", loads - l0, 1);
    chk("two_acks", acks - a0, 1);
    chk("two_add_a", cap_a, 32'h3F800000);
    chk("two_add_b", cap_b, 32'h40000000);
    chk("two_lat", ack_cyc - load_cyc, 4);

    // Sum held while the consumer stalls.
    stable = 1'b1;
    sd = sum_data;
    repeat (10) begin
      @(negedge clk);
      if (!sum_valid || sum_data !== sd || in_ready) stable = 1'b0;
    end
    chk("hold_stable", stable, 1);
    take_sum("hold");
    l0 = loads;
    send(32'h40000000, 1'b1);
    wait_sum(50, gap);
    chk("fresh_sum", sum_data, 32'h40000000);
    chk("fresh_loads", loads - l0, 0);
    take_sum("fresh");

    // in_ready turnaround after a non-last added term; three-term sum.
    send(32'h3F800000, 1'b0);
    send(32'h40000000, 1'b0);
    gap = 0;
    while (gap < 50) begin
      @(negedge clk);
      if (in_ready) break;
      gap++;
    end
    chk("ready_gap", gap, 5);
    send(32'h3F800000, 1'b1);
    wait_sum(50, gap);
    chk("three_sum", sum_data, 32'h40800000);
    chk("three_cnt", term_count, 3);
    take_sum("three");

    // sum_ack outside DONE has no effect.
    @(negedge clk);
    sum_ack = 1'b1;
    @(negedge clk);
    sum_ack = 1'b0;
    chk("stray_ack_ready", in_ready, 1);
    chk("stray_ack_valid", sum_valid, 0);

    // Zero terms: skipped with the macro, added without it.
    l0 = loads;
    send(32'h3F800000, 1'b0);
    send(32'h00000000, 1'b0);
    send(32'h80000000, 1'b0);
    send(32'h40000000, 1'b1);
    wait_sum(100, gap);
    chk("zero_sum", sum_data, 32'h40400000);
    chk("zero_cnt", term_count, 4);
`ifdef FP_ACC_ZERO_SKIP_EN
    chk("zero_loads", loads - l0, 1);
`else
    chk("zero_loads", loads - l0, 3);
`endif
    take_sum("zero");

    // Adder never answers.
    stub_dead = 1'b1;
    l0 = loads; a0 = acks;
    send(32'h3F800000, 1'b0);
    send(32'h40000000, 1'b1);
    wait_sum(100, gap);
    chk("to_err", err_timeout, 1);
    chk("to_sum", sum_data, 32'h3F800000);
    chk("to_cnt", term_count, 2);
    chk("to_lat", ack_cyc - load_cyc, TIMEOUT + 1);
    chk("to_acks", acks - a0, 1);
    repeat (3) @(negedge clk);
    chk("to_err_held", err_timeout, 1);
    take_sum("to");
    chk("to_err_clr", err_timeout, 0);
    stub_dead = 1'b0;

    // Reset while waiting on the adder.
    a0 = acks;
    send(32'h3F800000, 1'b0);
    send(32'h40000000, 1'b0);
    @(negedge clk);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_flags", {27'd0, in_ready, add_load, add_result_ack, sum_valid, err_timeout}, 0);
    chk("mid_rst_a", add_a, 0);
    chk("mid_rst_b", add_b, 0);
    chk("mid_rst_cnt", term_count, 0);
    chk("mid_rst_sum", sum_data, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_ready", in_ready, 1);
    chk("mid_rst_noack", acks - a0, 0);
    send(32'h40000000, 1'b0);
    send(32'h3F800000, 1'b1);
    wait_sum(50, gap);
    chk("post_rst_sum", sum_data, 32'h40400000);
    chk("post_rst_cnt", term_count, 2);
    take_sum("post_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
